// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states, byte width and
// the pointer wrap helper used for round-robin rotation.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 10417;
  localparam int UART_BYTE_W       = 8;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } arb_state_e;

  // Explicit wrap so non-power-of-two requester counts rotate correctly.
  function automatic int wrap_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req_mask at or above ptr,
// wrapping at N-1 back to 0. Returns a one-hot grant and its binary index.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_mask,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         any_grant
);

  always_comb begin
    int cand;
    cand      = 0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!any_grant && req_mask[cand]) begin
        any_grant   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ producers.
// Optional message locking is enabled with `define UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_start,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic [ID_W-1:0]              grant_id,
  output logic                         arb_busy
);

  arb_state_e             state_q, state_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   lock_active_q, lock_active_d;

  logic [N_REQ-1:0] lock_mask;
  logic [N_REQ-1:0] elig_mask;
  logic [N_REQ-1:0] pick_grant;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;

`ifndef UART_ARB_PKT_LOCK_EN
  logic unused_req_last;
  assign unused_req_last = ^req_last;
`endif

  // While a message is locked only its owner may be picked.
  assign lock_mask = N_REQ'(1) << grant_id_q;
  assign elig_mask = lock_active_q ? (req_valid & lock_mask) : req_valid;

  rr_pick #(
    .N (N_REQ),
    .W (ID_W)
  ) u_rr_pick (
    .req_mask  (elig_mask),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_grant (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    lock_active_d = lock_active_q;
    req_ready     = '0;
    tx_start      = 1'b0;
    case (state_q)
      ARB: begin
        // No byte is taken in a reset cycle, so the strobe is gated by reset.
        if (pick_any && reset) begin
          req_ready  = pick_grant;
          tx_data_d  = req_data[UART_BYTE_W*int'(pick_idx) +: UART_BYTE_W];
          grant_id_d = pick_idx;
          state_d    = START;
`ifdef UART_ARB_PKT_LOCK_EN
          lock_active_d = !req_last[pick_idx];
`endif
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!tx_busy) begin
          if (!lock_active_q) rr_ptr_d = ID_W'(wrap_next(int'(grant_id_q), N_REQ));
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ARB;
      tx_data_q     <= '0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      lock_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_data_q     <= tx_data_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_active_q <= lock_active_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign grant_id = grant_id_q;
  assign arb_busy = (state_q != ARB);

endmodule
